// File: rtl/idct_2d_rowcol.sv
// idct_2d_rowcol: sequential 8x8 2-D inverse DCT using one shared 8-MAC engine for the row and column passes
module idct_2d_rowcol #(
  parameter int P_N_DIM  = 8,
  parameter int P_DATA_W = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [P_N_DIM*P_N_DIM*P_DATA_W-1:0]    Z_in_flat,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [P_N_DIM*P_N_DIM*P_DATA_W-1:0]    x_out_flat
);
  localparam int N  = P_N_DIM;
  localparam int W  = P_DATA_W;
  localparam int NN = N * N;
  localparam int AW = W + 16 + 3;
  localparam logic signed [AW-1:0] LP_RND = AW'(1) <<< 13;
  localparam logic signed [AW-1:0] LP_MAX = (AW'(1) <<< (W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] LP_MIN = -LP_MAX - AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [5:0]            r_cnt;
  logic signed [W-1:0]   r_z [NN];
  logic signed [W-1:0]   r_t [NN];
  logic signed [W-1:0]   r_x [NN];
  logic [2:0]            w_a, w_b;
  logic signed [AW-1:0]  w_acc, w_sh;
  logic signed [W-1:0]   w_res;

  // sqrt(2)*16384*cos(a*pi/16) for a in 1..8
  function automatic logic signed [15:0] f_c(input logic [4:0] a);
    case (a)
      5'd1:    f_c = 16'sd22725;
      5'd2:    f_c = 16'sd21407;
      5'd3:    f_c = 16'sd19266;
      5'd4:    f_c = 16'sd16384;
      5'd5:    f_c = 16'sd12873;
      5'd6:    f_c = 16'sd8867;
      5'd7:    f_c = 16'sd4520;
      default: f_c = 16'sd0;
    endcase
  endfunction

  // Q2.14 cosine ROM K[i][k]; angle index (2i+1)k folded mod 32 onto the first quadrant
  function automatic logic signed [15:0] f_k(input logic [2:0] i, input logic [2:0] k);
    logic [4:0] j, a;
    j = {1'b0, i, 1'b1} * {2'b00, k};
    a = j[4] ? 5'd0 - j : j;
    return (k == 3'd0) ? 16'sd16384 : (a > 5'd8) ? -f_c(5'd16 - a) : f_c(a);
  endfunction

  assign w_a       = r_cnt[5:3];
  assign w_b       = r_cnt[2:0];
  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  for (genvar i = 0; i < NN; i++) begin : g_out
    assign x_out_flat[i*W +: W] = r_x[i];
  end

  // eight-term dot product: rows of Z against K in pass 1, columns of T against K in pass 2
  always_comb begin
    w_acc = '0;
    for (int j = 0; j < N; j++)
      w_acc = w_acc + ((r_state == S_PASS2)
        ? AW'(f_k(w_a, 3'(j))) * AW'(r_t[{3'(j), w_b}])
        : AW'(f_k(w_b, 3'(j))) * AW'(r_z[{w_a, 3'(j)}]));
    w_sh  = (w_acc + LP_RND) >>> 14;
    w_res = (w_sh > LP_MAX) ? W'(LP_MAX) : (w_sh < LP_MIN) ? W'(LP_MIN) : w_sh[W-1:0];
  end

  // next-state logic: accept, two 64-cycle passes, then hold until the output handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = in_valid  ? S_PASS1 : S_IDLE;
      S_PASS1: w_state_nxt = (&r_cnt)  ? S_PASS2 : S_PASS1;
      S_PASS2: w_state_nxt = (&r_cnt)  ? S_DONE  : S_PASS2;
      S_DONE:  w_state_nxt = out_ready ? S_IDLE  : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;

  // element counter; wraps 63->0 at the pass boundary so pass 2 starts with no bubble
  always_ff @(posedge clk or posedge rst)
    if (rst)                                              r_cnt <= '0;
    else if (r_state == S_PASS1 || r_state == S_PASS2)    r_cnt <= r_cnt + 6'd1;
    else                                                  r_cnt <= '0;

  // coefficient capture on the accepting edge only
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NN; i++) r_z[i] <= '0;
    else if (in_valid && r_state == S_IDLE)
      for (int i = 0; i < NN; i++) r_z[i] <= Z_in_flat[i*W +: W];

  // transpose buffer written by the row pass
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NN; i++) r_t[i] <= '0;
    else if (r_state == S_PASS1) r_t[r_cnt] <= w_res;

  // output block written by the column pass, held otherwise
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NN; i++) r_x[i] <= '0;
    else if (r_state == S_PASS2) r_x[r_cnt] <= w_res;
endmodule

// File: tb/tb_idct_2d_rowcol.sv
// tb_idct_2d_rowcol: directed checks of the 8x8 inverse DCT
module tb_idct_2d_rowcol;
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [1023:0] Z_in_flat = '0, x_out_flat;
  int            nvec = 0, nbad = 0;
  int            sat_col [8] = '{32767, 32767, 32767, 32767, 23727, 7022, -5764, -12682};
  int            rt_x [64];
  logic [1023:0] z_dc1, z_dc2, z_sat, z_rt, snap;
  time           t_acc, t_acc2, t_d, t_v;
  time           ta [3];

  always #5 clk = ~clk;

  idct_2d_rowcol dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Z_in_flat(Z_in_flat),
    .out_valid(out_valid), .out_ready(out_ready), .x_out_flat(x_out_flat)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int xo(int i);
    return int'($signed(x_out_flat[i*16 +: 16]));
  endfunction

  task automatic chk(input string tag, input int got, input int exp, input int tol);
    nvec++;
    if (got - exp > tol || exp - got > tol) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic send(input logic [1023:0] z, output time t);
    int n = 0;
    Z_in_flat = z;
    in_valid  = 1'b1;
    while (!in_ready && n < 400) begin @(negedge clk); n++; end
    chk("accept_wait", int'(in_ready), 1, 0);
    @(posedge clk);
    t = $time;
    @(negedge clk);
    in_valid  = 1'b0;
    Z_in_flat = {64{16'h5A5A}};
  endtask

  task automatic wait_done(output time t);
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    chk("done_wait", int'(out_valid), 1, 0);
    t = $time - 5;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_in_ready", int'(in_ready), 1, 0);
    chk("hs_out_valid", int'(out_valid), 0, 0);
  endtask

  task automatic chk_blk(input string tag, input int kind, input int dcv);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s[%0d][%0d]", tag, i / 8, i % 8), xo(i),
          kind == 0 ? dcv : kind == 1 ? sat_col[i % 8] : rt_x[i],
          kind == 0 ? 2 : kind == 1 ? 0 : 130);
  endtask

  initial begin
    real pi, a [8][8], xm [8][8], zr;
    int q;
    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        a[k][n] = (k == 0 ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0)) * $cos((2 * n + 1) * k * pi / 16.0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) xm[r][c] = r * 0.12 + c * 0.08 - 0.6;
    xm[0][0] = 0.75; xm[1][2] = -0.5; xm[7][6] = 0.25;
    z_rt = '0;
    for (int u = 0; u < 8; u++)
      for (int v = 0; v < 8; v++) begin
        zr = 0.0;
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 8; j++) zr += a[u][i] * xm[i][j] * a[v][j];
        zr = zr / 8.0 * 32768.0;
        q  = $rtoi(zr >= 0.0 ? zr + 0.5 : zr - 0.5);
        q  = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
        z_rt[(u*8+v)*16 +: 16] = 16'(q);
      end
    for (int i = 0; i < 64; i++) begin
      zr = xm[i / 8][i % 8] * 32768.0;
      rt_x[i] = $rtoi(zr >= 0.0 ? zr + 0.5 : zr - 0.5);
    end
    z_dc1 = '0; z_dc1[15:0] = 16'h1000;
    z_dc2 = '0; z_dc2[15:0] = 16'h0800;
    z_sat = '0; z_sat[15:0] = 16'h7FFF; z_sat[31:16] = 16'h7FFF;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_x_zero", int'(x_out_flat == '0), 1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 1, 0);
    chk("idle_out_valid", int'(out_valid), 0, 0);

    send(z_dc1, t_acc);
    wait_done(t_v);
    chk("dc_latency", int'((t_v - t_acc) / 10), 128, 0);
    chk_blk("dc", 0, 4096);
    handshake();

    send(z_rt, t_acc);
    wait_done(t_v);
    chk("rt_latency", int'((t_v - t_acc) / 10), 128, 0);
    chk_blk("rt", 2, 0);
    handshake();

    send(z_sat, t_acc);
    wait_done(t_v);
    chk_blk("sat", 1, 0);
    handshake();

    send(z_dc2, t_acc);
    wait_done(t_v);
    chk_blk("bp_a", 0, 2048);
    snap      = x_out_flat;
    Z_in_flat = z_sat;
    in_valid  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("bp_out_valid", int'(out_valid), 1, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_x_stable", int'(x_out_flat == snap), 1, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    t_d = $time;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after_hs", int'(in_ready), 1, 0);
    @(posedge clk);
    t_acc2 = $time;
    @(negedge clk);
    chk("bp_accepted", int'(in_ready), 0, 0);
    in_valid  = 1'b0;
    Z_in_flat = {64{16'hA5A5}};
    wait_done(t_v);
    chk("bp_accept_edge", int'((t_acc2 - t_d) / 10), 1, 0);
    chk("bp_latency", int'((t_v - t_acc2) / 10), 128, 0);
    chk_blk("bp_b", 1, 0);
    handshake();

    send(z_rt, t_acc);
    repeat (30) @(posedge clk);
    chk("pre_rst_x_held", int'(x_out_flat != '0), 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_x_zero", int'(x_out_flat == '0), 1, 0);
    chk("mid_rst_out_valid", int'(out_valid), 0, 0);
    chk("mid_rst_in_ready", int'(in_ready), 1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1, 0);
    send(z_dc1, t_acc);
    wait_done(t_v);
    chk("post_rst_latency", int'((t_v - t_acc) / 10), 128, 0);
    chk_blk("post_rst_dc", 0, 4096);
    handshake();

    out_ready = 1'b1;
    fork
      begin
        send(z_dc1, ta[0]);
        send(z_sat, ta[1]);
        send(z_dc2, ta[2]);
      end
      begin
        wait_done(t_v); chk_blk("b2b0", 0, 4096); @(negedge clk);
        wait_done(t_v); chk_blk("b2b1", 1, 0);    @(negedge clk);
        wait_done(t_v); chk_blk("b2b2", 0, 2048); @(negedge clk);
      end
    join
    out_ready = 1'b0;
    chk("b2b_gap01", int'((ta[1] - ta[0]) / 10), 130, 0);
    chk("b2b_gap12", int'((ta[2] - ta[1]) / 10), 130, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
